// File: rtl/cla_pipe_addsub.sv
// -----------------------------------------------------------------------------
// cla_pipe_addsub
//   Pipelined carry-lookahead adder/subtractor. The operands are cut into
//   NSTG = WIDTH/GROUP groups. Stage k resolves group k with a GROUP-bit
//   lookahead block. The group carry-out is registered into stage k+1.
//   Operand bits that are not yet processed and result bits that are already
//   complete travel with the beat. The last stage writes straight into the
//   output registers, so a beat accepted at edge N is on the outputs after
//   edge N+NSTG-1. NSTG must be at least 2.
//
// Optional feature: define CLA_PIPE_SATURATE_EN to add the sat_mode input.
//   sat_mode is sampled with the operands. When it is set and the operation
//   overflows, the result clamps to the signed limit. carry_out, overflow,
//   isLessThan and isNotEqual still describe the raw wrapped result.
//
// Ports:
//   clock, reset_n     rising-edge clock, asynchronous active-low reset
//   flush              synchronous; kills every in-flight beat
//   in_valid/in_ready  operand handshake
//   data_operandA/B    operands; op_sub selects A+B (0) or A-B (1)
//   sat_mode           (CLA_PIPE_SATURATE_EN only) clamp on signed overflow
//   out_valid/out_ready result handshake
//   data_result        sum/difference (modulo 2^WIDTH unless clamped)
//   carry_out          carry out of bit WIDTH-1
//   overflow           signed overflow (carry into MSB ^ carry out of MSB)
//   isNotEqual         |raw result
//   isLessThan         raw result MSB ^ overflow
//
// Handshake: a beat transfers on a rising edge where valid && ready are both
//   high. Valid never depends on ready. in_ready is combinational:
//   in_ready = !out_valid || out_ready. The whole pipe shifts as one unit when
//   that term is high and holds when it is low. Cycles with in_valid low shift
//   a bubble in, and bubbles are not collapsed. flush clears every valid bit
//   and drops any offered beat. It takes priority over a stall.
// -----------------------------------------------------------------------------
module cla_pipe_addsub #(
  parameter int WIDTH = 32,
  parameter int GROUP = 8,
  parameter int NSTG  = WIDTH / GROUP
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             op_sub,
`ifdef CLA_PIPE_SATURATE_EN
  input  logic             sat_mode,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_result,
  output logic             carry_out,
  output logic             overflow,
  output logic             isNotEqual,
  output logic             isLessThan
);

  logic advance;
  logic sat_in;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

`ifdef CLA_PIPE_SATURATE_EN
  assign sat_in = sat_mode;
`else
  assign sat_in = 1'b0;
`endif

  // Stage registers between stages (index k holds the beat after group k).
  logic [NSTG-2:0]  stg_v;
  logic [NSTG-2:0]  stg_c;
  logic [NSTG-2:0]  stg_s;
  logic [WIDTH-1:0] stg_a [NSTG-1];
  logic [WIDTH-1:0] stg_b [NSTG-1];
  logic [WIDTH-1:0] stg_r [NSTG-1];

  // Inputs seen by each stage's combinational group logic.
  logic [NSTG-1:0]  in_v;
  logic [NSTG-1:0]  in_c;
  logic [NSTG-1:0]  in_s;
  logic [WIDTH-1:0] in_a [NSTG];
  logic [WIDTH-1:0] in_b [NSTG];
  logic [WIDTH-1:0] in_r [NSTG];

  // Stage outputs.
  logic [WIDTH-1:0] nxt_r [NSTG];
  logic [NSTG-1:0]  nxt_c;
  logic             last_cmsb;

  assign in_v = {stg_v, in_valid};
  assign in_c = {stg_c, op_sub};     // subtract: carry-in of 1 completes ~B + 1
  assign in_s = {stg_s, sat_in};

  for (genvar k = 0; k < NSTG; k++) begin : g_stg
    logic [GROUP-1:0] ga, gb, gp, gg, gs;
    logic [GROUP:0]   carry;
    logic [WIDTH-1:0] r_out;
    logic             t, pp;

    if (k == 0) begin : g_first
      assign in_a[k] = data_operandA;
      assign in_b[k] = op_sub ? ~data_operandB : data_operandB;
      assign in_r[k] = '0;
    end else begin : g_next
      assign in_a[k] = stg_a[k-1];
      assign in_b[k] = stg_b[k-1];
      assign in_r[k] = stg_r[k-1];
    end

    assign ga = in_a[k][k*GROUP +: GROUP];
    assign gb = in_b[k][k*GROUP +: GROUP];
    assign gp = ga ^ gb;
    assign gg = ga & gb;

    // Each carry is built from its own generate/propagate prefix and the
    // group carry-in, so no carry waits on the carry below it.
    always_comb begin
      carry    = '0;
      t        = 1'b0;
      pp       = 1'b0;
      carry[0] = in_c[k];
      for (int i = 0; i < GROUP; i++) begin
        t  = gg[i];
        pp = gp[i];
        for (int j = i - 1; j >= 0; j--) begin
          t  = t | (pp & gg[j]);
          pp = pp & gp[j];
        end
        carry[i+1] = t | (pp & in_c[k]);
      end
    end

    assign gs = gp ^ carry[GROUP-1:0];

    always_comb begin
      r_out = in_r[k];
      r_out[k*GROUP +: GROUP] = gs;
    end

    assign nxt_r[k] = r_out;
    assign nxt_c[k] = carry[GROUP];

    if (k == NSTG - 1) begin : g_last
      assign last_cmsb = carry[GROUP-1];
    end
  end

  // Final-stage result and flags, computed from the beat being registered.
  logic [WIDTH-1:0] raw_res;
  logic [WIDTH-1:0] fin_res;
  logic             raw_cout;
  logic             raw_ovf;

  assign raw_res  = nxt_r[NSTG-1];
  assign raw_cout = nxt_c[NSTG-1];
  assign raw_ovf  = last_cmsb ^ raw_cout;

  // Overflow flips the sign, so a raw negative MSB means positive overflow.
  always_comb begin
    fin_res = raw_res;
    if (in_s[NSTG-1] && raw_ovf) begin
      fin_res = raw_res[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}}
                                 : {1'b1, {(WIDTH-1){1'b0}}};
    end
  end

  // Valid bits: reset and flush clear them, otherwise they shift on advance.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stg_v     <= '0;
      out_valid <= 1'b0;
    end else if (flush) begin
      stg_v     <= '0;
      out_valid <= 1'b0;
    end else if (advance) begin
      stg_v     <= in_v[NSTG-2:0];
      out_valid <= in_v[NSTG-1];
    end
  end

  // Output registers are written only when the pipe advances.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      data_result <= '0;
      carry_out   <= 1'b0;
      overflow    <= 1'b0;
      isNotEqual  <= 1'b0;
      isLessThan  <= 1'b0;
    end else if (advance) begin
      data_result <= fin_res;
      carry_out   <= raw_cout;
      overflow    <= raw_ovf;
      isNotEqual  <= |raw_res;
      isLessThan  <= raw_res[WIDTH-1] ^ raw_ovf;
    end
  end

  // Datapath stage registers carry no reset. Their valid bits qualify them.
  always_ff @(posedge clock) begin
    if (advance) begin
      for (int k = 0; k < NSTG - 1; k++) begin
        stg_a[k] <= in_a[k];
        stg_b[k] <= in_b[k];
        stg_r[k] <= nxt_r[k];
        stg_c[k] <= nxt_c[k];
        stg_s[k] <= in_s[k];
      end
    end
  end

endmodule
